// File: rtl/inorder_issue_queue.sv
// In-order issue queue: DEPTH-entry circular buffer whose operands wake on tag match,
// with head-only issue through a registered valid/ready output stage.

module inorder_issue_queue_wkup #(
    parameter int WK_CNT = 2,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic                          src_rdy,
    input  logic [TAG_W-1:0]              src_tag,
    input  logic [DATA_W-1:0]             src_data,
    input  logic [WK_CNT-1:0]             wkup_valid,
    input  logic [WK_CNT-1:0][TAG_W-1:0]  wkup_tag,
    input  logic [WK_CNT-1:0][DATA_W-1:0] wkup_data,
    output logic                          rdy_nxt,
    output logic [DATA_W-1:0]             data_nxt
);
    always_comb begin
        rdy_nxt  = src_rdy;
        data_nxt = src_data;
        // descending scan: the lowest matching bus index is the final writer
        if (!src_rdy) begin
            for (int w = WK_CNT - 1; w >= 0; w--) begin
                if (wkup_valid[w] && wkup_tag[w] == src_tag) begin
                    rdy_nxt  = 1'b1;
                    data_nxt = wkup_data[w];
                end
            end
        end
    end
endmodule

module inorder_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int DISP_W    = 2,
    parameter int NSRC      = 2,
    parameter int WK_CNT    = 2,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 64,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       flush_i,
    input  logic [DISP_W-1:0]                          disp_valid_i,
    input  logic [DISP_W-1:0][PAYLOAD_W-1:0]           disp_payload_i,
    input  logic [DISP_W-1:0][NSRC-1:0][DATA_W-1:0]    disp_src_data_i,
    input  logic [DISP_W-1:0][NSRC-1:0][TAG_W-1:0]     disp_src_tag_i,
    input  logic [DISP_W-1:0][NSRC-1:0]                disp_src_rdy_i,
    output logic                                       disp_ready_o,
    output logic [CNT_W-1:0]                           free_cnt_o,
    input  logic [WK_CNT-1:0]                          wkup_valid_i,
    input  logic [WK_CNT-1:0][TAG_W-1:0]               wkup_tag_i,
    input  logic [WK_CNT-1:0][DATA_W-1:0]              wkup_data_i,
    output logic                                       iss_valid_o,
    input  logic                                       iss_ready_i,
    output logic [PAYLOAD_W-1:0]                       iss_payload_o,
    output logic [NSRC-1:0][DATA_W-1:0]                iss_src_data_o
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [PAYLOAD_W-1:0]            payload;
        logic [NSRC-1:0][DATA_W-1:0]     data;
        logic [NSRC-1:0][TAG_W-1:0]      tag;
        logic [NSRC-1:0]                 rdy;
    } ent_t;

    ent_t                                 ent_q [DEPTH];
    logic [DEPTH-1:0]                     ent_vld_q;
    logic [PTR_W-1:0]                     head_q, tail_q;
    logic [CNT_W-1:0]                     free_cnt_q;
    logic [DEPTH-1:0][NSRC-1:0]           res_rdy;
    logic [DEPTH-1:0][NSRC-1:0][DATA_W-1:0] res_data;
    logic [DISP_W-1:0][NSRC-1:0]          byp_rdy;
    logic [DISP_W-1:0][NSRC-1:0][DATA_W-1:0] byp_data;
    logic [DISP_W-1:0]                    disp_acc;
    logic [DISP_W-1:0][PTR_W-1:0]         disp_slot;
    logic [CNT_W-1:0]                     acc_cnt;
    logic                                 head_elig, load;

    // explicit wrap so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    assign disp_ready_o = (free_cnt_q >= CNT_W'(DISP_W));
    assign free_cnt_o   = free_cnt_q;

    generate
        for (genvar e = 0; e < DEPTH; e++) begin : g_res
            for (genvar s = 0; s < NSRC; s++) begin : g_src
                inorder_issue_queue_wkup #(.WK_CNT(WK_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_wk (
                    .src_rdy(ent_q[e].rdy[s]), .src_tag(ent_q[e].tag[s]), .src_data(ent_q[e].data[s]),
                    .wkup_valid(wkup_valid_i), .wkup_tag(wkup_tag_i), .wkup_data(wkup_data_i),
                    .rdy_nxt(res_rdy[e][s]), .data_nxt(res_data[e][s]));
            end
        end
        for (genvar l = 0; l < DISP_W; l++) begin : g_disp
            for (genvar s = 0; s < NSRC; s++) begin : g_src
                inorder_issue_queue_wkup #(.WK_CNT(WK_CNT), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_wk (
                    .src_rdy(disp_src_rdy_i[l][s]), .src_tag(disp_src_tag_i[l][s]),
                    .src_data(disp_src_data_i[l][s]),
                    .wkup_valid(wkup_valid_i), .wkup_tag(wkup_tag_i), .wkup_data(wkup_data_i),
                    .rdy_nxt(byp_rdy[l][s]), .data_nxt(byp_data[l][s]));
            end
        end
    endgenerate

    // compact accepted lanes onto consecutive slots starting at tail
    always_comb begin : disp_map
        int off;
        disp_acc  = '0;
        disp_slot = '0;
        off       = 0;
        for (int l = 0; l < DISP_W; l++) begin
            if (disp_ready_o && disp_valid_i[l]) begin
                disp_acc[l]  = 1'b1;
                disp_slot[l] = ptr_add(tail_q, off);
                off++;
            end
        end
        acc_cnt = CNT_W'(off);
    end

    assign head_elig = ent_vld_q[head_q] && (&ent_q[head_q].rdy);
    assign load      = head_elig && (!iss_valid_o || iss_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            free_cnt_q <= CNT_W'(DEPTH);
        end else if (flush_i) begin
            ent_vld_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            free_cnt_q <= CNT_W'(DEPTH);
        end else begin
            if (load) begin
                ent_vld_q[head_q] <= 1'b0;
                head_q            <= ptr_add(head_q, 1);
            end
            for (int l = 0; l < DISP_W; l++)
                if (disp_acc[l]) ent_vld_q[disp_slot[l]] <= 1'b1;
            tail_q     <= ptr_add(tail_q, int'(acc_cnt));
            free_cnt_q <= free_cnt_q - acc_cnt + CNT_W'(load);
        end
    end

    // entry contents are qualified by ent_vld_q, so they need no reset
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (ent_vld_q[e]) begin
                ent_q[e].rdy  <= res_rdy[e];
                ent_q[e].data <= res_data[e];
            end
        end
        for (int l = 0; l < DISP_W; l++) begin
            if (disp_acc[l]) begin
                ent_q[disp_slot[l]].payload <= disp_payload_i[l];
                ent_q[disp_slot[l]].tag     <= disp_src_tag_i[l];
                ent_q[disp_slot[l]].rdy     <= byp_rdy[l];
                ent_q[disp_slot[l]].data    <= byp_data[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_o    <= 1'b0;
            iss_payload_o  <= '0;
            iss_src_data_o <= '0;
        end else if (flush_i) begin
            iss_valid_o    <= 1'b0;
            iss_payload_o  <= '0;
            iss_src_data_o <= '0;
        end else if (load) begin
            iss_valid_o    <= 1'b1;
            iss_payload_o  <= ent_q[head_q].payload;
            iss_src_data_o <= ent_q[head_q].data;
        end else if (iss_ready_i) begin
            iss_valid_o    <= 1'b0;
        end
    end

    // a flush may legitimately clear a stalled output
    a_iss_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (iss_valid_o && !iss_ready_i && !flush_i) |=> $stable(iss_payload_o));
    a_free_max: assert property (@(posedge clk) disable iff (!rst_n)
        free_cnt_o <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_inorder_issue_queue.sv
// Drives an 8-deep and a 5-deep queue with identical stimulus and checks both every
// cycle against an ordered-list reference model of the queue and output stage.

module tb_inorder_issue_queue;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ir = 1'b0;
    logic [1:0]             dv = '0;
    logic [1:0][63:0]       dpay = '0;
    logic [1:0][1:0][31:0]  dsd = '0;
    logic [1:0][1:0][5:0]   dst = '0;
    logic [1:0][1:0]        dsr = '0;
    logic [1:0]             wv = '0;
    logic [1:0][5:0]        wt = '0;
    logic [1:0][31:0]       wd = '0;

    logic drdy8, drdy5, iv8, iv5;
    logic [3:0] fcnt8;
    logic [2:0] fcnt5;
    logic [63:0] ip8, ip5;
    logic [1:0][31:0] isd8, isd5;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    inorder_issue_queue #(.DEPTH(8)) u_q8 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .disp_valid_i(dv), .disp_payload_i(dpay),
        .disp_src_data_i(dsd), .disp_src_tag_i(dst), .disp_src_rdy_i(dsr),
        .disp_ready_o(drdy8), .free_cnt_o(fcnt8), .wkup_valid_i(wv), .wkup_tag_i(wt),
        .wkup_data_i(wd), .iss_valid_o(iv8), .iss_ready_i(ir), .iss_payload_o(ip8),
        .iss_src_data_o(isd8));

    inorder_issue_queue #(.DEPTH(5)) u_q5 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .disp_valid_i(dv), .disp_payload_i(dpay),
        .disp_src_data_i(dsd), .disp_src_tag_i(dst), .disp_src_rdy_i(dsr),
        .disp_ready_o(drdy5), .free_cnt_o(fcnt5), .wkup_valid_i(wv), .wkup_tag_i(wt),
        .wkup_data_i(wd), .iss_valid_o(iv5), .iss_ready_i(ir), .iss_payload_o(ip5),
        .iss_src_data_o(isd5));

    // reference model: each queue is an ordered list, oldest at index 0
    typedef struct packed {
        logic [63:0]       pay;
        logic [1:0][31:0]  dat;
        logic [1:0][5:0]   tag;
        logic [1:0]        rdy;
    } op_t;

    op_t              m_ops [2][8];
    int               m_cnt [2];
    int               m_depth [2];
    logic             m_ov [2];
    logic [63:0]      m_op [2];
    logic [1:0][31:0] m_od [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wake_idx(input logic [5:0] tag);
        for (int w = 0; w < 2; w++)
            if (wv[w] && wt[w] == tag) return w;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_ov[d] = 1'b0; m_op[d] = '0; m_od[d] = '0;
        end
    endtask

    task automatic model_step(input int d);
        int  fr, idx;
        bit  pop;
        op_t op;
        fr = m_depth[d] - m_cnt[d];
        if (flush) begin
            m_cnt[d] = 0; m_ov[d] = 1'b0; m_op[d] = '0; m_od[d] = '0;
            return;
        end
        pop = (!m_ov[d] || ir) && (m_cnt[d] > 0) && (&m_ops[d][0].rdy);
        if (pop) begin
            m_ov[d] = 1'b1; m_op[d] = m_ops[d][0].pay; m_od[d] = m_ops[d][0].dat;
        end else if (ir) begin
            m_ov[d] = 1'b0;
        end
        for (int i = 0; i < m_cnt[d]; i++)
            for (int s = 0; s < 2; s++)
                if (!m_ops[d][i].rdy[s]) begin
                    idx = wake_idx(m_ops[d][i].tag[s]);
                    if (idx >= 0) begin
                        m_ops[d][i].rdy[s] = 1'b1; m_ops[d][i].dat[s] = wd[idx];
                    end
                end
        if (pop) begin
            for (int i = 0; i < m_cnt[d] - 1; i++) m_ops[d][i] = m_ops[d][i+1];
            m_cnt[d]--;
        end
        if (fr >= 2)
            for (int l = 0; l < 2; l++)
                if (dv[l]) begin
                    op.pay = dpay[l]; op.dat = dsd[l]; op.tag = dst[l]; op.rdy = dsr[l];
                    for (int s = 0; s < 2; s++)
                        if (!op.rdy[s]) begin
                            idx = wake_idx(op.tag[s]);
                            if (idx >= 0) begin op.rdy[s] = 1'b1; op.dat[s] = wd[idx]; end
                        end
                    m_ops[d][m_cnt[d]] = op;
                    m_cnt[d]++;
                end
    endtask

    task automatic check_all();
        chk("q8_valid", iv8, m_ov[0]);
        chk("q8_payload", ip8, m_op[0]);
        chk("q8_srcdata", isd8, m_od[0]);
        chk("q8_free", fcnt8, 8 - m_cnt[0]);
        chk("q8_drdy", drdy8, (8 - m_cnt[0]) >= 2);
        chk("q5_valid", iv5, m_ov[1]);
        chk("q5_payload", ip5, m_op[1]);
        chk("q5_srcdata", isd5, m_od[1]);
        chk("q5_free", fcnt5, 5 - m_cnt[1]);
        chk("q5_drdy", drdy5, (5 - m_cnt[1]) >= 2);
    endtask

    task automatic cyc();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_lane(input int l, input logic [63:0] p, input logic [1:0] r,
                            input logic [5:0] t0, input logic [5:0] t1,
                            input logic [31:0] d0, input logic [31:0] d1);
        dpay[l] = p; dsr[l] = r;
        dst[l][0] = t0; dst[l][1] = t1;
        dsd[l][0] = d0; dsd[l][1] = d1;
    endtask

    task automatic idle();
        dv = '0; wv = '0; flush = 1'b0;
    endtask

    initial begin
        m_depth[0] = 8;
        m_depth[1] = 5;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid8", iv8, 1'b0);
        chk("rst_free8", fcnt8, 4'd8);
        chk("rst_drdy8", drdy8, 1'b1);
        chk("rst_free5", fcnt5, 3'd5);
        chk("rst_pay8", ip8, 64'd0);
        rst_n = 1'b1;

        // two ready ops in one cycle issue back to back
        ir = 1'b1;
        set_lane(0, 64'hA, 2'b11, 6'd0, 6'd0, 32'h11, 32'h12);
        set_lane(1, 64'hB, 2'b11, 6'd0, 6'd0, 32'h21, 32'h22);
        dv = 2'b11;
        cyc();
        idle();
        cyc();
        chk("t2_A_valid", iv8, 1'b1);
        chk("t2_A_pay", ip8, 64'hA);
        cyc();
        chk("t2_B_pay", ip8, 64'hB);
        cyc();
        chk("t2_free", fcnt8, 4'd8);

        // head waits on tag 5 while the younger op is ready
        set_lane(0, 64'hC, 2'b10, 6'd5, 6'd0, 32'h0, 32'h31);
        set_lane(1, 64'hD, 2'b11, 6'd0, 6'd0, 32'h41, 32'h42);
        dv = 2'b11;
        cyc();
        idle();
        repeat (3) cyc();
        chk("t3_blocked", iv8, 1'b0);
        wv = 2'b01; wt[0] = 6'd5; wd[0] = 32'h00001234;
        cyc();
        idle();
        cyc();
        chk("t3_C_pay", ip8, 64'hC);
        chk("t3_C_data", isd8[0], 32'h00001234);
        cyc();
        chk("t3_D_pay", ip8, 64'hD);
        repeat (2) cyc();

        // enqueue bypass with two matching buses: bus 0 wins
        set_lane(0, 64'hE, 2'b10, 6'd9, 6'd0, 32'h0, 32'h51);
        dv = 2'b01;
        wv = 2'b11; wt[0] = 6'd9; wt[1] = 6'd9; wd[0] = 32'hBEEF; wd[1] = 32'hCAFE;
        cyc();
        idle();
        cyc();
        chk("t4_valid", iv8, 1'b1);
        chk("t4_data", isd8[0], 32'hBEEF);
        repeat (2) cyc();

        // backpressure fill, then drain
        ir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_lane(0, 64'h500 + 64'(2*i), 2'b11, 6'd0, 6'd0, 32'(i), 32'h0);
            set_lane(1, 64'h501 + 64'(2*i), 2'b11, 6'd0, 6'd0, 32'h0, 32'(i));
            dv = 2'b11;
            cyc();
        end
        chk("t5_drdy8", drdy8, 1'b0);
        chk("t5_free5", fcnt5, 3'd0);
        chk("t5_hold_pay", ip8, 64'h500);
        idle();
        ir = 1'b1;
        repeat (12) cyc();
        chk("t5_drained", fcnt8, 4'd8);

        // sparse lane 1 only, wrapping the 5-deep ring
        for (int i = 0; i < 7; i++) begin
            set_lane(1, 64'h600 + 64'(i), 2'b11, 6'd0, 6'd0, 32'(i), 32'h0);
            dv = 2'b10;
            cyc();
        end
        idle();
        repeat (4) cyc();

        // flush with a stalled, valid output stage
        ir = 1'b0;
        set_lane(0, 64'h700, 2'b11, 6'd0, 6'd0, 32'h7, 32'h8);
        dv = 2'b01;
        cyc();
        idle();
        cyc();
        chk("t6_stalled", iv5, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t6_flush_valid", iv5, 1'b0);
        chk("t6_flush_free", fcnt5, 3'd5);

        // asynchronous reset while entries wait on an absent tag
        set_lane(0, 64'h800, 2'b00, 6'd63, 6'd63, 32'h0, 32'h0);
        set_lane(1, 64'h801, 2'b00, 6'd63, 6'd63, 32'h0, 32'h0);
        dv = 2'b11;
        cyc();
        idle();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid8", iv8, 1'b0);
        chk("arst_free8", fcnt8, 4'd8);
        chk("arst_drdy8", drdy8, 1'b1);
        chk("arst_free5", fcnt5, 3'd5);
        model_reset();
        rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int l = 0; l < 2; l++)
                set_lane(l, {$urandom, $urandom}, 2'($urandom), 6'($urandom_range(0, 7)),
                         6'($urandom_range(0, 7)), $urandom, $urandom);
            dv = 2'($urandom);
            wv = 2'($urandom);
            wt[0] = 6'($urandom_range(0, 7));
            wt[1] = 6'($urandom_range(0, 7));
            wd[0] = $urandom;
            wd[1] = $urandom;
            ir = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            cyc();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
